dac_spi_tx: RTL and testbench

- Serial transmitter for a MAX5134-style SPI DAC.
- On a one-cycle `send` strobe it captures a 24-bit word (8-bit command, then 16-bit sample) and shifts it out MSB-first under an active-low chip select.
- Sits between the oscillator sample-timing logic (one strobe per sample interval, ~1910 clocks at 84 MHz) and the DAC pins.
- SCLK is derived from the system clock by an integer divider.

---
 rtl/dac_spi_tx.sv | 121 ++++++++++++
 tb/tb_dac_spi_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI transmitter for a MAX5134-style DAC: one strobe sends one MSB-first frame under active-low CS.
// SCLK idles high, and the DAC samples DIN on the falling edge. DIN changes only when SCLK rises.
//
// state  | meaning
// IDLE   | CS high, waiting for a send strobe
// LEAD   | CS low, SCLK high, first bit set up before the first falling edge
// LOW    | SCLK low half-period, DAC samples the current bit
// HIGH   | SCLK high half-period
// GAP    | CS high recovery time, busy still asserted
module dac_spi_tx #(
  parameter int DATA_WIDTH  = 24,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  send,
  output logic                  spi_cs_out,
  output logic                  spi_clock_out,
  output logic                  spi_data_out,
  output logic                  busy
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_LOW, S_HIGH, S_GAP} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-2:0] shreg_q;  // bits still to send; the current bit sits in dout_q
  logic                  cs_q;
  logic                  sclk_q;
  logic                  dout_q;
  logic                  busy_q;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (send) begin
            shreg_q <= data_in[DATA_WIDTH-2:0];
            dout_q  <= data_in[DATA_WIDTH-1];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            bit_q   <= BIT_LOAD;
            state_q <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_LOAD;
            sclk_q  <= 1'b0;
            state_q <= S_LOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_LOAD;
            sclk_q  <= 1'b1;
            state_q <= S_HIGH;
            // Advance the bit on the rising edge so DIN holds across the whole falling-edge window.
            if (bit_q != '0) begin
              dout_q  <= shreg_q[DATA_WIDTH-2];
              shreg_q <= {shreg_q[DATA_WIDTH-3:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_LOAD;
            if (bit_q == '0) begin
              cs_q    <= 1'b1;
              dout_q  <= 1'b0;
              state_q <= S_GAP;
            end else begin
              bit_q   <= bit_q - 1'b1;
              sclk_q  <= 1'b0;
              state_q <= S_LOW;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          // A held strobe is only seen in IDLE, so back-to-back frames keep CS high for GAP plus one cycle.
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_cs_out    = cs_q;
  assign spi_clock_out = sclk_q;
  assign spi_data_out  = dout_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx. A frame-level reference model predicts which strobes are accepted and which words are sent.
// Pin monitors decode the SPI frames and compare them against that prediction.
module tb_dac_spi_tx;

  localparam int N  = 24;
  localparam int H  = 2;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [N-1:0]  din   = '0;
  logic          snd   = 1'b0;
  logic          cs, sclk, sdo, bsy;
  logic [N-1:0]  din2  = '0;
  logic          snd2  = 1'b0;
  logic          cs2, sclk2, sdo2, bsy2;

  dac_spi_tx #(.DATA_WIDTH(N), .HALF_PERIOD(H)) u_dut (
    .clock_in(clk), .reset(rst_n), .data_in(din), .send(snd),
    .spi_cs_out(cs), .spi_clock_out(sclk), .spi_data_out(sdo), .busy(bsy));

  dac_spi_tx #(.DATA_WIDTH(N), .HALF_PERIOD(H1)) u_dut_fast (
    .clock_in(clk), .reset(rst_n), .data_in(din2), .send(snd2),
    .spi_cs_out(cs2), .spi_clock_out(sclk2), .spi_data_out(sdo2), .busy(bsy2));

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a strobe is accepted only once the previous frame's busy window, including the cycle where busy falls, has ended.
  int           cyc       = 0;
  int           next_free = 0;
  logic [N-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      next_free = 0;
    end else if (snd && cyc >= next_free) begin
      exp_q.push_back(din);
      next_free = cyc + H * (2 + 2 * N) + 1;
    end
  end

  // Pin monitor for the HALF_PERIOD=2 instance.
  logic         p_cs = 1'b1, p_sclk = 1'b1, p_busy = 1'b0, p_sdo = 1'b0;
  int           n_fall = 0, cs_low = 0, busy_len = 0, sclk_glitch = 0, stab_err = 0, frames_done = 0;
  logic [N-1:0] cap = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_fall = 0; cs_low = 0; busy_len = 0; cap = '0;
      p_cs = 1'b1; p_sclk = 1'b1; p_busy = 1'b0; p_sdo = 1'b0;
    end else begin
      if (cs && !sclk) sclk_glitch++;
      if (!cs && !sclk && !p_sclk && sdo !== p_sdo) stab_err++;
      if (!cs) begin
        cs_low++;
        if (p_sclk && !sclk) begin
          cap = {cap[N-2:0], sdo};
          n_fall++;
        end
      end
      if (bsy) busy_len++;
      if (!p_cs && cs) begin
        chk("falling_edges", n_fall, N);
        chk("cs_low_clocks", cs_low, H * (1 + 2 * N));
        if (exp_q.size() == 0) chk("frame_expected", 0, 1);
        else chk("frame_word", cap, exp_q.pop_front());
        frames_done++;
        n_fall = 0; cs_low = 0; cap = '0;
      end
      if (p_busy && !bsy) begin
        chk("busy_clocks", busy_len, H * (2 + 2 * N));
        busy_len = 0;
      end
      p_cs = cs; p_sclk = sclk; p_busy = bsy; p_sdo = sdo;
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bsy) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic pulse_send(input logic [N-1:0] w);
    @(posedge clk); #1;
    din = w; snd = 1'b1;
    @(posedge clk); #1;
    snd = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"},   cs,   1'b1);
    chk({tag, "_sclk"}, sclk, 1'b1);
    chk({tag, "_data"}, sdo,  1'b0);
    chk({tag, "_busy"}, bsy,  1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dev;
    int f0;
    logic [N-1:0] w;

    // Reset, then idle.
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("in_reset");
    rst_n = 1'b1;
    dev = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs !== 1'b1 || sclk !== 1'b1 || sdo !== 1'b0 || bsy !== 1'b0) dev++;
    end
    chk("idle_stable", dev, 0);

    // Single frame; CS falls one clock after the strobe, with the MSB already on DIN.
    @(posedge clk); #1;
    din = 24'h31A5C3; snd = 1'b1;
    @(posedge clk); #1;
    snd = 1'b0;
    chk("accept_cs",   cs,   1'b0);
    chk("accept_busy", bsy,  1'b1);
    chk("accept_sclk", sclk, 1'b1);
    chk("accept_msb",  sdo,  1'b0);
    din = 24'hFFFFFF;
    wait_idle(200);

    // All ones, then all zeros, with data_in scrambled during each frame.
    for (int k = 0; k < 2; k++) begin
      pulse_send(k == 0 ? 24'hFFFFFF : 24'h000000);
      repeat (50) begin
        @(posedge clk); #1 din = N'($urandom);
      end
      wait_idle(200);
    end

    // Strobe at clock 40 of a frame is ignored.
    f0 = frames_done;
    pulse_send(24'h5A3C96);
    repeat (39) @(posedge clk);
    #1 snd = 1'b1; din = 24'h123456;
    @(posedge clk); #1 snd = 1'b0;
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("ignored_mid_frame", frames_done - f0, 1);
    pulse_send(24'hC0FFEE);
    wait_idle(200);
    chk("next_send_accepted", frames_done - f0, 2);

    // A strobe on the edge where busy falls is also ignored.
    f0 = frames_done;
    pulse_send(24'h8E1D42);
    repeat (99) @(posedge clk);
    #1 snd = 1'b1;
    @(posedge clk); #1 snd = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_fall_ignored_cs",   cs,  1'b1);
    chk("busy_fall_ignored_busy", bsy, 1'b0);
    wait_idle(200);
    chk("busy_fall_frames", frames_done - f0, 1);

    // Reset after ten falling edges aborts the frame at once.
    pulse_send(N'($urandom));
    dev = 0;
    for (int i = 0; i < 200 && n_fall < 10; i++) @(negedge clk);
    chk("reached_10_falls", n_fall, 10);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    f0 = frames_done;
    pulse_send(N'($urandom));
    wait_idle(200);
    chk("post_reset_frame", frames_done - f0, 1);

    // Randomized traffic: stray strobes, data churn and held strobes, all predicted by the model.
    for (int k = 0; k < 10; k++) begin
      pulse_send(N'($urandom));
      for (int j = 0; j < 110; j++) begin
        @(posedge clk); #1;
        snd = ($urandom_range(0, 15) == 0);
        din = N'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        snd = 1'b1;
        repeat ($urandom_range(1, 150)) @(posedge clk);
        #1;
      end
      snd = 1'b0;
      wait_idle(400);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    chk("sclk_idle_high", sclk_glitch, 0);
    chk("data_stable_low", stab_err, 0);

    // HALF_PERIOD=1 with the strobe held high: back-to-back frames.
    begin
      logic pc, ps;
      int nf, hi, cl, frames2, gl2;
      bit started;
      logic [N-1:0] cw;
      pc = 1'b1; ps = 1'b1; nf = 0; hi = 0; cl = 0; frames2 = 0; gl2 = 0; started = 0; cw = '0;
      w = N'($urandom);
      @(posedge clk); #1;
      din2 = w; snd2 = 1'b1;
      repeat (300) begin
        @(negedge clk);
        if (cs2 && !sclk2) gl2++;
        if (!cs2) begin
          cl++;
          if (ps && !sclk2) begin
            cw = {cw[N-2:0], sdo2};
            nf++;
          end
        end
        if (pc && !cs2 && started) chk("b2b_cs_high", hi, H1 + 1);
        if (!pc && cs2) begin
          chk("b2b_falls", nf, N);
          chk("b2b_word", cw, w);
          chk("b2b_cs_low", cl, H1 * (1 + 2 * N));
          frames2++;
          nf = 0; cl = 0; cw = '0; hi = 1; started = 1;
        end else if (cs2) begin
          hi++;
        end
        pc = cs2; ps = sclk2;
      end
      #1 snd2 = 1'b0;
      chk("b2b_frame_count", frames2 >= 5, 1'b1);
      chk("b2b_sclk_idle", gl2, 0);
      dev = 0;
      for (int i = 0; i < 200 && (bsy2 || !cs2); i++) begin
        @(negedge clk);
        dev++;
      end
      chk("b2b_drain", bsy2, 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
